// File: rtl/adder_result_accumulator.sv
// ============================================================================
// adder_result_accumulator
// Sums the four 2-bit adder lanes over a WINDOW-sample window and presents
// the total and an overflow flag through a valid/ready output handshake.
// Optional build macro: ACC_SATURATE_EN (clamp instead of wrap on overflow).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_result_accumulator #(
    parameter int ACC_W  = 10,
    parameter int WINDOW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       z,
    input  logic [1:0]       x,
    input  logic [1:0]       y,
    input  logic [1:0]       v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ovf_trk, ovf_trk_n;
    logic [ACC_W-1:0] acc_out_n;
    logic             overflow_n;
    logic             out_valid_n;

    logic [3:0]       term;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_add;
    logic             accept;

    assign in_ready = ena & (state != DONE);
    assign busy     = (state != IDLE);
    assign accept   = ena & in_valid & in_ready;

    assign term  = {2'b00, z} + {2'b00, x} + {2'b00, y} + {2'b00, v};
    assign sum   = {1'b0, acc} + (ACC_W + 1)'(term);
    assign carry = sum[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, further non-negative terms keep the sum at all-ones.
    assign acc_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        ovf_trk_n   = ovf_trk;
        acc_out_n   = acc_out;
        overflow_n  = overflow;
        out_valid_n = out_valid;

        if (ena && clear) begin
            state_n     = IDLE;
            acc_n       = '0;
            cnt_n       = '0;
            ovf_trk_n   = 1'b0;
            overflow_n  = 1'b0;
            out_valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_n     = ACC_W'(term);
                        cnt_n     = CNT_W'(1);
                        ovf_trk_n = 1'b0;
                        if (WINDOW == 1) begin
                            state_n     = DONE;
                            acc_out_n   = ACC_W'(term);
                            overflow_n  = 1'b0;
                            out_valid_n = 1'b1;
                        end else begin
                            state_n = ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_n     = acc_add;
                        cnt_n     = cnt + CNT_W'(1);
                        ovf_trk_n = ovf_trk | carry;
                        if (cnt == CNT_W'(WINDOW - 1)) begin
                            state_n     = DONE;
                            acc_out_n   = acc_add;
                            overflow_n  = ovf_trk | carry;
                            out_valid_n = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ena && out_ready) begin
                        state_n     = IDLE;
                        acc_n       = '0;
                        cnt_n       = '0;
                        ovf_trk_n   = 1'b0;
                        out_valid_n = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf_trk   <= 1'b0;
            acc_out   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf_trk   <= ovf_trk_n;
            acc_out   <= acc_out_n;
            overflow  <= overflow_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adder_result_accumulator.sv
// ============================================================================
// tb_adder_result_accumulator
// Directed bench: default instance (ACC_W=10) plus a narrow ACC_W=6 instance
// sharing the same stimulus, so both walk identical state sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_result_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena, clear, in_valid, out_ready;
    logic [1:0] z, x, y, v;

    logic       in_ready, out_valid, overflow, busy;
    logic [9:0] acc_out;
    logic       in_ready6, out_valid6, overflow6, busy6;
    logic [5:0] acc_out6;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    adder_result_accumulator #(.ACC_W(10), .WINDOW(8)) dut (
        .clk(clk), .reset(reset), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .z(z), .x(x), .y(y), .v(v),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .overflow(overflow), .busy(busy)
    );

    adder_result_accumulator #(.ACC_W(6), .WINDOW(8)) dut6 (
        .clk(clk), .reset(reset), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready6),
        .z(z), .x(x), .y(y), .v(v),
        .out_valid(out_valid6), .out_ready(out_ready),
        .acc_out(acc_out6), .overflow(overflow6), .busy(busy6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic [1:0] a, b, c, d);
        z = a; x = b; y = c; v = d;
    endtask

    task automatic test_reset();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        vectors++; if (acc_out !== 10'd0) begin errors++; $display("FAIL rst_acc_out got %0d exp 0", acc_out); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        ena = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        // Fill a window and park in DONE, then hit reset mid-cycle.
        in_valid = 1'b1; out_ready = 1'b0; lanes(3, 3, 3, 3);
        repeat (8) tick();
        in_valid = 1'b0;
        vectors++; if (acc_out !== 10'd96) begin errors++; $display("FAIL rst_prefill got %0d exp 96", acc_out); end
        ena = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++; if ({out_valid, overflow, busy, in_ready} !== 4'b0000) begin errors++; $display("FAIL rst_async_flags got %b exp 0000", {out_valid, overflow, busy, in_ready}); end
        vectors++; if (acc_out !== 10'd0) begin errors++; $display("FAIL rst_async_acc got %0d exp 0", acc_out); end
        reset = 1'b0;
        ena   = 1'b1;
        tick();
        vectors++; if ({in_ready, busy} !== 2'b10) begin errors++; $display("FAIL rst_release got %b exp 10", {in_ready, busy}); end
    endtask

    task automatic test_full_window();
        in_valid = 1'b1; out_ready = 1'b0; lanes(3, 3, 3, 3);
        for (int i = 0; i < 8; i++) begin
            vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL fw_accept%0d got rdy=%b ov=%b exp 1/0", i, in_ready, out_valid); end
            tick();
        end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fw_out_valid got %b exp 1", out_valid); end
        vectors++; if (acc_out !== 10'd96) begin errors++; $display("FAIL fw_acc_out got %0d exp 96", acc_out); end
        vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL fw_overflow got %b exp 0", overflow); end
        vectors++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fw_ready_busy got %b%b exp 01", in_ready, busy); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; out_ready = 1'b0; lanes(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b1 || acc_out !== 10'd96 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got ov=%b acc=%0d rdy=%b exp 1/96/0", i, out_valid, acc_out, in_ready); end
        end
        // ena low in DONE must block the handshake.
        ena = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_ena_gate got %b exp 1", out_valid); end
        ena = 1'b1;
        tick();
        vectors++; if ({out_valid, in_ready, busy} !== 3'b010) begin errors++; $display("FAIL bp_release got %b exp 010", {out_valid, in_ready, busy}); end
        vectors++; if (acc_out !== 10'd96) begin errors++; $display("FAIL bp_acc_keep got %0d exp 96", acc_out); end
        // Back-to-back: next window starts the cycle after the handshake.
        out_ready = 1'b0; in_valid = 1'b1;
        tick();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_start got %b exp 1", busy); end
        repeat (7) tick();
        vectors++; if (out_valid !== 1'b1 || acc_out !== 10'd8) begin errors++; $display("FAIL b2b_total got ov=%b acc=%0d exp 1/8", out_valid, acc_out); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [5:0] exp6;
`ifdef ACC_SATURATE_EN
        exp6 = 6'd63;
`else
        exp6 = 6'd32;
`endif
        in_valid = 1'b1; lanes(3, 3, 3, 3);
        repeat (8) tick();
        in_valid = 1'b0;
        vectors++; if (out_valid6 !== 1'b1 || acc_out6 !== exp6) begin errors++; $display("FAIL ovf_acc6 got ov=%b acc=%0d exp 1/%0d", out_valid6, acc_out6, exp6); end
        vectors++; if (overflow6 !== 1'b1) begin errors++; $display("FAIL ovf_flag6 got %b exp 1", overflow6); end
        vectors++; if (acc_out !== 10'd96 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_wide got acc=%0d of=%b exp 96/0", acc_out, overflow); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_clear();
        in_valid = 1'b1; lanes(3, 3, 3, 3);
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++; if ({busy, out_valid, in_ready} !== 3'b001) begin errors++; $display("FAIL clr_idle got %b exp 001", {busy, out_valid, in_ready}); end
        vectors++; if (acc_out !== 10'd96) begin errors++; $display("FAIL clr_acc_keep got %0d exp 96", acc_out); end
        lanes(1, 0, 0, 0);
        repeat (8) tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || acc_out !== 10'd8 || overflow !== 1'b0) begin errors++; $display("FAIL clr_total got ov=%b acc=%0d of=%b exp 1/8/0", out_valid, acc_out, overflow); end
        vectors++; if (acc_out6 !== 6'd8 || overflow6 !== 1'b0) begin errors++; $display("FAIL clr_total6 got acc=%0d of=%b exp 8/0", acc_out6, overflow6); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_ena_gating();
        in_valid = 1'b1; lanes(2, 1, 0, 0);
        repeat (3) tick();
        ena = 1'b0; lanes(3, 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gate_ready%0d got %b exp 0", i, in_ready); end
            tick();
        end
        ena = 1'b1; lanes(2, 1, 0, 0);
        repeat (4) tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gate_count7 got %b exp 0", out_valid); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || acc_out !== 10'd24) begin errors++; $display("FAIL gate_total got ov=%b acc=%0d exp 1/24", out_valid, acc_out); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        lanes(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_full_window();
        test_backpressure();
        test_overflow();
        test_clear();
        test_ena_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
